// File: rtl/lcd_cmd_host_if.sv
`default_nettype none
// ============================================================================
// lcd_cmd_host_if : command and IRAM-capture signals between host and controller
// Rev 1.0 : initial release
// ============================================================================
interface lcd_cmd_host_if;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       busy;
  logic       done;
  logic       IRAM_valid;
  logic [5:0] IRAM_A;
  logic [7:0] IRAM_D;

  modport master (
    output cmd, cmd_valid,
    input  busy, done, IRAM_valid, IRAM_A, IRAM_D
  );

  modport slave (
    input  cmd, cmd_valid,
    output busy, done, IRAM_valid, IRAM_A, IRAM_D
  );
endinterface
`default_nettype wire

// File: rtl/lcd_cmd_host.sv
`default_nettype none
// ============================================================================
// lcd_cmd_host : queues opcodes, issues them under the controller busy
//                handshake and captures the IRAM write stream
// Rev 1.0 : initial release
// ============================================================================
module lcd_cmd_host #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           q_cmd,
  input  logic                 q_push,
  output logic                 q_full,
  output logic                 q_empty,
  lcd_cmd_host_if.master       bus,
  input  logic [5:0]           cap_addr,
  output logic [7:0]           cap_data,
  output logic [6:0]           wr_count,
  output logic [15:0]          checksum,
  output logic [7:0]           cmds_issued,
  output logic                 finished,
  output logic                 timeout_err
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [c_TMR_W-1:0] c_TMO = c_TMR_W'(TIMEOUT);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_ISSUE     = 3'd1;
  localparam logic [2:0] c_GUARD     = 3'd2;
  localparam logic [2:0] c_WAIT_RDY  = 3'd3;
  localparam logic [2:0] c_WAIT_DONE = 3'd4;
  localparam logic [2:0] c_FINISH    = 3'd5;
  localparam logic [2:0] c_HALT      = 3'd6;

  logic [2:0]          r_state;
  logic [3:0]          r_cmd;
  logic [c_TMR_W-1:0]  r_timer;
  logic [7:0]          r_cmds_issued;
  logic                r_finished;
  logic                r_timeout_err;
  logic [6:0]          r_wr_count;
  logic [15:0]         r_checksum;

  logic [3:0]          r_fifo [FIFO_DEPTH];
  logic [c_PTR_W:0]    r_wr_ptr;
  logic [c_PTR_W:0]    r_rd_ptr;
  logic [7:0]          r_cap [64];

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [3:0]          w_head;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                   (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
  assign w_push  = q_push && !w_full;
  assign w_pop   = (r_state == c_ISSUE);
  assign w_head  = r_fifo[r_rd_ptr[c_PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr[c_PTR_W-1:0]] <= q_cmd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= c_IDLE;
      r_cmd         <= 4'd0;
      r_timer       <= '0;
      r_cmds_issued <= 8'd0;
      r_finished    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (!bus.busy && !w_empty) begin
            r_cmd   <= w_head;
            r_state <= c_ISSUE;
          end
        end
        c_ISSUE: begin
          r_cmds_issued <= r_cmds_issued + 8'd1;
          r_timer       <= '0;
          r_state       <= (r_cmd == 4'd0) ? c_WAIT_DONE : c_GUARD;
        end
        c_GUARD: begin
          // Short ops may never raise busy, so its first cycle is not trusted.
          r_timer <= '0;
          r_state <= c_WAIT_RDY;
        end
        c_WAIT_RDY: begin
          if (!bus.busy) begin
            r_state <= c_IDLE;
          end else if (r_timer == c_TMO) begin
            r_timeout_err <= 1'b1;
            r_state       <= c_HALT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        c_WAIT_DONE: begin
          if (bus.done) begin
            r_finished <= 1'b1;
            r_state    <= c_FINISH;
          end else if (r_timer == c_TMO) begin
            r_timeout_err <= 1'b1;
            r_state       <= c_HALT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        c_FINISH: r_state <= c_FINISH;
        c_HALT:   r_state <= c_HALT;
        default:  r_state <= c_IDLE;
      endcase
    end
  end

  // Capture buffer contents survive reset; only the statistics are cleared.
  always_ff @(posedge clk) begin
    if (bus.IRAM_valid) begin
      r_cap[bus.IRAM_A] <= bus.IRAM_D;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_count <= 7'd0;
      r_checksum <= 16'd0;
    end else if (bus.IRAM_valid) begin
      r_checksum <= r_checksum + {8'd0, bus.IRAM_D};
      if (r_wr_count != 7'd127) begin
        r_wr_count <= r_wr_count + 7'd1;
      end
    end
  end

  assign bus.cmd       = r_cmd;
  assign bus.cmd_valid = (r_state == c_ISSUE);
  assign q_full        = w_full;
  assign q_empty       = w_empty;
  assign cap_data      = r_cap[cap_addr];
  assign wr_count      = r_wr_count;
  assign checksum      = r_checksum;
  assign cmds_issued   = r_cmds_issued;
  assign finished      = r_finished;
  assign timeout_err   = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_host.sv
`default_nettype none
// ============================================================================
// tb_lcd_cmd_host : directed self-checking bench for lcd_cmd_host
// Rev 1.0 : initial release
// ============================================================================
module tb_lcd_cmd_host;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  q_cmd;
  logic        q_push;
  logic        q_full;
  logic        q_empty;
  logic [5:0]  cap_addr;
  logic [7:0]  cap_data;
  logic [6:0]  wr_count;
  logic [15:0] checksum;
  logic [7:0]  cmds_issued;
  logic        finished;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [3:0] log_cmd [$];
  int         log_cyc [$];

  lcd_cmd_host_if bus();

  lcd_cmd_host #(
    .FIFO_DEPTH (16),
    .TIMEOUT    (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .q_cmd       (q_cmd),
    .q_push      (q_push),
    .q_full      (q_full),
    .q_empty     (q_empty),
    .bus         (bus),
    .cap_addr    (cap_addr),
    .cap_data    (cap_data),
    .wr_count    (wr_count),
    .checksum    (checksum),
    .cmds_issued (cmds_issued),
    .finished    (finished),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every strobe is logged with the cycle it occupied.
  always @(negedge clk) begin
    if (bus.cmd_valid) begin
      log_cmd.push_back(bus.cmd);
      log_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] op);
    q_cmd  = op;
    q_push = 1'b1;
    tick();
    q_push = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int bound);
    int n;
    n = 0;
    while (!bus.cmd_valid && n < bound) begin
      tick();
      n++;
    end
    if (!bus.cmd_valid) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic clear_log();
    log_cmd.delete();
    log_cyc.delete();
  endtask

  initial begin
    int fall;
    int n;
    int nines;
    int s;

    reset          = 1'b1;
    q_cmd          = 4'd0;
    q_push         = 1'b0;
    cap_addr       = 6'd0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.IRAM_valid = 1'b0;
    bus.IRAM_A     = 6'd0;
    bus.IRAM_D     = 8'd0;
    tick();
    tick();

    chk("rst_cmd",         bus.cmd,       0);
    chk("rst_cmd_valid",   bus.cmd_valid, 0);
    chk("rst_q_empty",     q_empty,       1);
    chk("rst_q_full",      q_full,        0);
    chk("rst_wr_count",    wr_count,      0);
    chk("rst_checksum",    checksum,      0);
    chk("rst_cmds_issued", cmds_issued,   0);
    chk("rst_finished",    finished,      0);
    chk("rst_timeout_err", timeout_err,   0);
    reset = 1'b0;
    tick();

    // Step 1: three opcodes, controller idle.
    clear_log();
    push(4'd4);
    push(4'd2);
    push(4'd7);
    repeat (20) tick();
    chk("t1_strobes", log_cmd.size(), 3);
    if (log_cmd.size() == 3) begin
      chk("t1_cmd0", log_cmd[0], 4);
      chk("t1_cmd1", log_cmd[1], 2);
      chk("t1_cmd2", log_cmd[2], 7);
      chk("t1_gap01", (log_cyc[1] - log_cyc[0]) >= 3, 1);
      chk("t1_gap12", (log_cyc[2] - log_cyc[1]) >= 3, 1);
    end
    chk("t1_cmds_issued", cmds_issued, 3);
    chk("t1_q_empty",     q_empty,     1);

    // Step 2: busy held high for three cycles after the strobe.
    clear_log();
    push(4'd5);
    wait_valid("t2_wait5", 10);
    bus.busy = 1'b1;
    push(4'd6);
    tick();
    tick();
    bus.busy = 1'b0;
    fall = cyc;
    repeat (10) tick();
    chk("t2_strobes", log_cmd.size(), 2);
    if (log_cmd.size() == 2) begin
      chk("t2_cmd0",      log_cmd[0], 5);
      chk("t2_cmd1",      log_cmd[1], 6);
      chk("t2_not_early", log_cyc[1] >= fall + 1, 1);
      chk("t2_issue_cyc", log_cyc[1], fall + 2);
    end
    chk("t2_cmds_issued", cmds_issued, 5);
    chk("t2_cmd_hold",    bus.cmd,     6);

    // Step 3: image write-out then done.
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    chk("t3_done_idle", finished, 0);
    for (int a = 0; a < 64; a++) begin
      bus.IRAM_valid = 1'b1;
      bus.IRAM_A     = 6'(a);
      bus.IRAM_D     = 8'(a + 1);
      tick();
    end
    bus.IRAM_valid = 1'b0;
    chk("t3_wr_count", wr_count, 64);
    chk("t3_checksum", checksum, 2080);
    cap_addr = 6'd10;
    #1;
    chk("t3_cap10", cap_data, 11);
    bus.IRAM_valid = 1'b1;
    bus.IRAM_A     = 6'd10;
    bus.IRAM_D     = 8'h55;
    tick();
    bus.IRAM_valid = 1'b0;
    chk("t3_dup_count",    wr_count, 65);
    chk("t3_dup_checksum", checksum, 2165);
    chk("t3_dup_cap10",    cap_data, 8'h55);
    push(4'd0);
    wait_valid("t3_wait0", 10);
    chk("t3_cmd0", bus.cmd, 0);
    tick();
    chk("t3_not_yet", finished, 0);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    chk("t3_finished", finished, 1);
    clear_log();
    push(4'd3);
    repeat (10) tick();
    chk("t3_finish_no_issue", log_cmd.size(), 0);
    chk("t3_cmds_issued",     cmds_issued,    6);

    // Step 4: fill queue while controller busy.
    do_reset();
    bus.busy = 1'b1;
    for (int i = 0; i < 15; i++) push(4'd3);
    chk("t4_not_full_15", q_full, 0);
    push(4'd3);
    chk("t4_full_16",  q_full,  1);
    chk("t4_nonempty", q_empty, 0);
    push(4'd9);
    chk("t4_still_full", q_full, 1);
    clear_log();
    bus.busy = 1'b0;
    repeat (90) tick();
    chk("t4_strobes", log_cmd.size(), 16);
    nines = 0;
    foreach (log_cmd[i]) if (log_cmd[i] == 4'd9) nines++;
    chk("t4_dropped_op", nines, 0);
    chk("t4_cmds_issued", cmds_issued, 16);
    chk("t4_drained", q_empty, 1);

    // Step 5: busy stuck high after strobe.
    push(4'd1);
    wait_valid("t5_wait1", 10);
    bus.busy = 1'b1;
    n = 0;
    while (!timeout_err && n < 11) begin
      tick();
      n++;
    end
    chk("t5_timeout_err", timeout_err, 1);
    chk("t5_within_11",   n <= 11,     1);
    s = log_cmd.size();
    push(4'd2);
    bus.busy = 1'b0;
    repeat (20) tick();
    chk("t5_halt_no_issue", log_cmd.size(), s);
    chk("t5_cmds_issued",   cmds_issued,    17);

    // Step 6: reset in the middle of operation.
    do_reset();
    chk("t6_q_cleared", q_empty, 1);
    bus.IRAM_valid = 1'b1;
    tick();
    bus.IRAM_valid = 1'b0;
    push(4'd7);
    wait_valid("t6_wait7", 10);
    reset = 1'b1;
    #1;
    chk("t6_async_valid", bus.cmd_valid, 0);
    chk("t6_async_cmd",   bus.cmd,       0);
    reset = 1'b0;
    tick();
    bus.IRAM_valid = 1'b1;
    tick();
    bus.IRAM_valid = 1'b0;
    push(4'd0);
    wait_valid("t6_wait0", 10);
    tick();
    reset = 1'b1;
    #1;
    chk("t6_cmd",         bus.cmd,       0);
    chk("t6_cmd_valid",   bus.cmd_valid, 0);
    chk("t6_q_empty",     q_empty,       1);
    chk("t6_q_full",      q_full,        0);
    chk("t6_wr_count",    wr_count,      0);
    chk("t6_checksum",    checksum,      0);
    chk("t6_cmds_issued", cmds_issued,   0);
    chk("t6_finished",    finished,      0);
    chk("t6_timeout_err", timeout_err,   0);
    tick();
    reset = 1'b0;
    tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    chk("t6_done_after_reset", finished,    0);
    chk("t6_no_issue",         cmds_issued, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
